// File: rtl/clk_enables_gen_if.sv
// ---------------------------------------------------------------------------
// clk_enables_gen_if
// Bundles the request inputs and the strobe outputs of clk_enables_gen.
//   turbo_req     : requested CPU speed mode (0 = base, higher = faster)
//   CPUContention : ULA contention request (only honoured in mode 0)
//   cpu_hold      : suppresses cpu_en while high
//   div_en        : bit k strobes when cnt[k:0] == 0
//   div_en_half   : bit k strobes when cnt[k:0] == 2^k
//   div_en_late   : bit k strobes when cnt[k:0] is all ones
//   cpu_en        : CPU clock enable
//   turbo_mode    : currently active speed mode
//   turbo_ack     : one-cycle pulse after the active mode changes
// master drives the requests; slave (the generator) drives the strobes.
// ---------------------------------------------------------------------------
interface clk_enables_gen_if #(
    parameter int DIVW   = 4,
    parameter int TURBOW = 2
);
    logic [TURBOW-1:0] turbo_req;
    logic              CPUContention;
    logic              cpu_hold;
    logic [DIVW-1:0]   div_en;
    logic [DIVW-1:0]   div_en_half;
    logic [DIVW-1:0]   div_en_late;
    logic              cpu_en;
    logic [TURBOW-1:0] turbo_mode;
    logic              turbo_ack;

    modport master (
        output turbo_req, CPUContention, cpu_hold,
        input  div_en, div_en_half, div_en_late, cpu_en, turbo_mode, turbo_ack
    );

    modport slave (
        input  turbo_req, CPUContention, cpu_hold,
        output div_en, div_en_half, div_en_late, cpu_en, turbo_mode, turbo_ack
    );
endinterface

// File: rtl/clk_enables_gen.sv
// ---------------------------------------------------------------------------
// clk_enables_gen
// Free-running binary master counter that produces power-of-two clock-enable
// strobes plus a CPU clock enable whose period is set by a turbo mode.
// Ports:
//   clk : master clock
//   rst : asynchronous active-high reset
//   bus : clk_enables_gen_if.slave (requests in, strobes out)
// All strobes are registered decodes of the counter value before the edge,
// so every output lags its counter value by one cycle. The turbo mode only
// changes on the wrap edge, so a CPU cycle is never cut short.
// ---------------------------------------------------------------------------
module clk_enables_gen #(
    parameter int DIVW   = 4,
    parameter int TURBOW = 2
) (
    input  logic               clk,
    input  logic               rst,
    clk_enables_gen_if.slave   bus
);

    logic [DIVW-1:0]   cnt_reg;
    logic [TURBOW-1:0] mode_reg;
    logic              chg_pending_reg;
    logic              turbo_ack_reg;
    logic              cpu_en_reg;
    logic [DIVW-1:0]   div_en_reg;
    logic [DIVW-1:0]   div_en_half_reg;
    logic [DIVW-1:0]   div_en_late_reg;

    logic [DIVW-1:0]   div_en_next;
    logic [DIVW-1:0]   div_en_half_next;
    logic [DIVW-1:0]   div_en_late_next;
    logic [DIVW-1:0]   tick_mask;
    logic              tick;
    logic              wrap;
    logic              cpu_en_next;
    logic              chg_pending_next;
    logic [TURBOW-1:0] mode_next;

    assign wrap = &cnt_reg;

    // Per-bit phase decodes of the counter.
    generate
        for (genvar gi = 0; gi < DIVW; gi++) begin : g_div
            localparam int HALF = 1 << gi;
            assign div_en_next[gi]      = (cnt_reg[gi:0] == '0);
            assign div_en_half_next[gi] = (cnt_reg[gi:0] == HALF[gi:0]);
            assign div_en_late_next[gi] = &cnt_reg[gi:0];
        end
    endgenerate

    // CPU period exponent p = max(DIVW-1-mode, 0); the tick fires when the
    // low p counter bits are zero. Oversized modes saturate to p = 0.
    always_comb begin
        int p_int;
        tick_mask = '0;
        if (int'(mode_reg) >= DIVW - 1) begin
            p_int = 0;
        end else begin
            p_int = DIVW - 1 - int'(mode_reg);
        end
        for (int i = 0; i < DIVW; i++) begin
            if (i < p_int) begin
                tick_mask[i] = 1'b1;
            end
        end
        tick = ((cnt_reg & tick_mask) == '0);
    end

    // Contention only stalls the base-speed CPU; a suppressed tick is lost.
    // mode_reg here is the pre-edge value, so a wrap edge that changes the
    // mode still uses the old mode for its own cpu_en.
    always_comb begin
        cpu_en_next      = tick & ~bus.cpu_hold
                           & ~((mode_reg == '0) & bus.CPUContention);
        mode_next        = mode_reg;
        chg_pending_next = 1'b0;
        if (wrap) begin
            mode_next        = bus.turbo_req;
            chg_pending_next = (bus.turbo_req != mode_reg);
        end
    end

    // The acknowledge is delayed one extra cycle through chg_pending_reg so
    // it lines up with the first post-wrap cycle (div_en[DIVW-1]).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= '0;
            mode_reg        <= '0;
            chg_pending_reg <= 1'b0;
            turbo_ack_reg   <= 1'b0;
            cpu_en_reg      <= 1'b0;
            div_en_reg      <= '0;
            div_en_half_reg <= '0;
            div_en_late_reg <= '0;
        end else begin
            cnt_reg         <= cnt_reg + 1'b1;
            mode_reg        <= mode_next;
            chg_pending_reg <= chg_pending_next;
            turbo_ack_reg   <= chg_pending_reg;
            cpu_en_reg      <= cpu_en_next;
            div_en_reg      <= div_en_next;
            div_en_half_reg <= div_en_half_next;
            div_en_late_reg <= div_en_late_next;
        end
    end

    assign bus.div_en      = div_en_reg;
    assign bus.div_en_half = div_en_half_reg;
    assign bus.div_en_late = div_en_late_reg;
    assign bus.cpu_en      = cpu_en_reg;
    assign bus.turbo_mode  = mode_reg;
    assign bus.turbo_ack   = turbo_ack_reg;

endmodule

// File: tb/tb_clk_enables_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_enables_gen
// Directed testbench for clk_enables_gen (DIVW=4, TURBOW=2). Each clock step
// pushes the expected outputs of a cycle-level reference onto a queue; the
// entry is popped and compared just after the edge. Directed pattern checks
// on recorded strobe cycles cover the scenario-level timing.
// ---------------------------------------------------------------------------
module tb_clk_enables_gen;

    localparam int DIVW   = 4;
    localparam int TURBOW = 2;
    localparam int PERIOD = 1 << DIVW;

    typedef struct packed {
        logic [DIVW-1:0]   de;
        logic [DIVW-1:0]   dh;
        logic [DIVW-1:0]   dl;
        logic              cpu;
        logic [TURBOW-1:0] mode;
        logic              ack;
    } exp_t;

    logic clk;
    logic rst;

    clk_enables_gen_if #(.DIVW(DIVW), .TURBOW(TURBOW)) bus ();

    clk_enables_gen #(.DIVW(DIVW), .TURBOW(TURBOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb_q[$];

    // reference state
    int m_cnt  = 0;
    int m_mode = 0;
    int m_pend = 0;

    // per-cycle observation masks, bit n = cycle n after reset release
    logic [63:0] div3_seen;
    logic [63:0] late2_seen;
    logic [63:0] cpu_seen;
    logic [63:0] ack_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive inputs for the next edge, predict, clock, compare.
    task automatic step(input logic [TURBOW-1:0] req, input logic cont, input logic hold);
        exp_t e;
        exp_t got;
        int   p;
        bus.turbo_req     = req;
        bus.CPUContention = cont;
        bus.cpu_hold      = hold;
        for (int k = 0; k < DIVW; k++) begin
            e.de[k] = ((m_cnt % (2 << k)) == 0);
            e.dh[k] = ((m_cnt % (2 << k)) == (1 << k));
            e.dl[k] = ((m_cnt % (2 << k)) == ((2 << k) - 1));
        end
        p = (m_mode >= DIVW - 1) ? 0 : (DIVW - 1 - m_mode);
        e.cpu = ((m_cnt % (1 << p)) == 0) && !hold && !(m_mode == 0 && cont);
        e.ack = (m_pend != 0);
        if (m_cnt == PERIOD - 1) begin
            m_pend = (int'(req) != m_mode) ? 1 : 0;
            m_mode = int'(req);
        end else begin
            m_pend = 0;
        end
        e.mode = m_mode[TURBOW-1:0];
        m_cnt  = (m_cnt + 1) % PERIOD;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        check("div_en",      64'(bus.div_en),      64'(got.de));
        check("div_en_half", 64'(bus.div_en_half), 64'(got.dh));
        check("div_en_late", 64'(bus.div_en_late), 64'(got.dl));
        check("cpu_en",      64'(bus.cpu_en),      64'(got.cpu));
        check("turbo_mode",  64'(bus.turbo_mode),  64'(got.mode));
        check("turbo_ack",   64'(bus.turbo_ack),   64'(got.ack));
        if (cyc < 64) begin
            div3_seen[cyc]  = bus.div_en[3];
            late2_seen[cyc] = bus.div_en_late[2];
            cpu_seen[cyc]   = bus.cpu_en;
            ack_seen[cyc]   = bus.turbo_ack;
        end
        $display("cyc=%0d req=%0d cont=%0b hold=%0b div_en=%b half=%b late=%b cpu_en=%b mode=%0d ack=%b",
                 cyc, req, cont, hold, bus.div_en, bus.div_en_half, bus.div_en_late,
                 bus.cpu_en, bus.turbo_mode, bus.turbo_ack);
    endtask

    task automatic run(input int n, input logic [TURBOW-1:0] req);
        for (int i = 0; i < n; i++) step(req, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_div_en"},     64'(bus.div_en),      64'd0);
        check({tag, "_half"},       64'(bus.div_en_half), 64'd0);
        check({tag, "_late"},       64'(bus.div_en_late), 64'd0);
        check({tag, "_cpu_en"},     64'(bus.cpu_en),      64'd0);
        check({tag, "_turbo_mode"}, 64'(bus.turbo_mode),  64'd0);
        check({tag, "_turbo_ack"},  64'(bus.turbo_ack),   64'd0);
    endtask

    // Asserts reset mid-period (called 1 time unit after an edge), checks the
    // outputs clear at once, holds across one edge, releases away from edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst               = 1'b0;
        bus.turbo_req     = '0;
        bus.CPUContention = 1'b0;
        bus.cpu_hold      = 1'b0;
        m_cnt  = 0;
        m_mode = 0;
        m_pend = 0;
        cyc    = 0;
        sb_q.delete();
        div3_seen  = '0;
        late2_seen = '0;
        cpu_seen   = '0;
        ack_seen   = '0;
    endtask

    function automatic logic [63:0] bits3(input int a, input int b, input int c);
        logic [63:0] r;
        r = '0;
        if (a > 0) r[a] = 1'b1;
        if (b > 0) r[b] = 1'b1;
        if (c > 0) r[c] = 1'b1;
        return r;
    endfunction

    initial begin
        logic [63:0] w;
        int          exp_cnt [1:3];
        exp_cnt[1] = 4;
        exp_cnt[2] = 8;
        exp_cnt[3] = 16;

        rst               = 1'b1;
        bus.turbo_req     = '0;
        bus.CPUContention = 1'b0;
        bus.cpu_hold      = 1'b0;
        @(posedge clk);
        #1;

        // Base mode after reset release
        do_reset();
        run(33, 2'd0);
        check("s1_div3_cycles",  div3_seen,  bits3(1, 17, 33));
        check("s1_late2_cycles", late2_seen, bits3(8, 16, 24) | bits3(32, 0, 0));
        check("s1_cpu_cycles",   cpu_seen,   bits3(1, 9, 17) | bits3(25, 33, 0));

        // Modes 1..3 requested from reset; new period after first wrap
        for (int m = 1; m <= 3; m++) begin
            do_reset();
            run(32, TURBOW'(m));
            w = cpu_seen >> 17;
            check("s2_cpu_count", 64'($countones(w[15:0])), 64'(exp_cnt[m]));
            check("s2_ack_cycle", ack_seen, bits3(17, 0, 0));
        end

        // Request 0 -> 3 presented at cnt=5
        do_reset();
        run(5, 2'd0);
        run(28, 2'd3);
        check("s3_ack_cycle",     ack_seen, bits3(17, 0, 0));
        check("s3_cpu_pre_wrap",  64'(cpu_seen[16:0]), bits3(1, 9, 0));
        w = cpu_seen >> 17;
        check("s3_cpu_continuous", 64'(w[15:0]), 64'hFFFF);

        // Contention across the cycle-9 tick in mode 0
        do_reset();
        run(7, 2'd0);
        for (int i = 0; i < 3; i++) step(2'd0, 1'b1, 1'b0);
        run(8, 2'd0);
        check("s4_contention_drop", 64'(cpu_seen[18:0]), bits3(1, 17, 0));

        // Same contention in mode 2 has no effect; then hold drops one tick
        do_reset();
        run(17, 2'd2);
        for (int i = 0; i < 3; i++) step(2'd2, 1'b1, 1'b0);
        run(5, 2'd2);
        for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 1'b1);
        run(4, 2'd2);
        w = cpu_seen >> 17;
        check("s4_mode2_contention", 64'(w[7:0]), 64'h55);
        w = cpu_seen >> 25;
        check("s5_hold_drop",        64'(w[7:0]), 64'h51);

        // Reset right after a wrap that latched a new mode, ack still pending
        do_reset();
        run(16, 2'd3);
        check("s6_mode_latched", 64'(bus.turbo_mode), 64'd3);
        do_reset();
        run(17, 2'd0);
        check("s6_ack_cleared", ack_seen, 64'd0);
        check("s6_div3_cycles", div3_seen, bits3(1, 17, 0));
        check("s6_cpu_cycles",  cpu_seen,  bits3(1, 9, 17));
        check("s6_sb_empty",    64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_enables_gen.md
Name: clk_enables_gen

Overview:
- Parametrised successor to the fixed 16-phase clock-enable generator.
- A binary master counter produces power-of-two clock-enable strobes for video, ULA and audio logic, plus a CPU clock enable.
- CPU speed comes from a generalised turbo mode. Mode changes apply only at master-period boundaries, so the CPU never sees a truncated cycle.
- The block adds ULA contention gating (base speed only), a CPU hold input and a turbo-change acknowledge.

Parameters:
- DIVW, 4: master counter width. Master period = 2^DIVW clk cycles (16 → 1.75 MHz from 28 MHz).
- TURBOW, 2: width of turbo request/mode. Mode m selects a CPU enable period of 2^max(DIVW-1-m, 0) cycles.

Ports:
- clk, in, 1: master clock.
- rst, in, 1: asynchronous active-high reset.
- turbo_req, in, TURBOW: requested CPU speed mode. 0 = base, higher = faster.
- CPUContention, in, 1: ULA contention request. Honoured only in mode 0.
- cpu_hold, in, 1: suppresses cpu_en while high (any mode).
- div_en, out, DIVW: bit k strobes when cnt[k:0]==0. Period 2^(k+1).
- div_en_half, out, DIVW: bit k strobes when cnt[k:0]==2^k. Half-period-shifted phase of div_en[k].
- div_en_late, out, DIVW: bit k strobes when cnt[k:0] is all ones. Cycle before div_en[k].
- cpu_en, out, 1: CPU clock enable.
- turbo_mode, out, TURBOW: currently active mode.
- turbo_ack, out, 1: one-cycle pulse when turbo_mode changes.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, mode_q=0.
  - All outputs 0: div_en, div_en_half, div_en_late, cpu_en, turbo_ack, turbo_mode.
- Counter:
  - cnt (DIVW bits) increments every clk edge and wraps 2^DIVW-1 → 0.
  - No enable input; free-running.
- Output timing:
  - All outputs are registered decodes of the pre-edge cnt (one-cycle lag).
  - First edge after reset release: div_en = all ones, div_en_half = 0, div_en_late = 0.
- DIVW=4 equivalents:
  - div_en[0]=14 MHz, div_en[1]=7 MHz, div_en_half[1]=7 MHz inverted phase.
  - div_en[2]=3.5 MHz, div_en_late[2]=3.5 MHz late phase (cnt 7,15), div_en[3]=1.75 MHz.
- Turbo:
  - turbo_req is sampled only on the edge where cnt==2^DIVW-1 (wrap edge).
  - At that edge mode_q <= turbo_req. Request changes at other times are ignored until the next wrap edge; the latest value wins.
  - turbo_ack=1 for exactly one cycle, in the cycle after mode_q changes. No pulse if the value is unchanged.
  - The new mode governs cpu_en from the first post-wrap cycle, aligned with div_en[DIVW-1].
- Period decode with p = max(DIVW-1-mode_q, 0):
  - tick = (p==0) or cnt[p-1:0]==0.
  - Modes ≥ DIVW-1 give tick every cycle.
  - Mode values above the maximum saturate to p=0.
- cpu_en:
  - cpu_en <= tick & !cpu_hold & !(mode_q==0 & CPUContention).
  - Inputs are sampled on the same edge as the cnt decode.
  - A suppressed tick is dropped, not deferred.
- Simultaneous events: if a wrap edge both changes mode and coincides with a tick, cpu_en for that edge uses the old mode_q.
- Reset mid-operation: asynchronously clears everything, including a pending turbo change. Counting restarts from 0.

Test Plan:
- Reset release, DIVW=4, turbo_req=0, no contention or hold → div_en[3] high on cycles 1,17,33. div_en[0] on every odd cycle. div_en_late[2] on cycles 8,16. cpu_en on cycles 1,9,17.
- Modes 1/2/3 held from reset, each run separately → after first wrap, cpu_en period is 4, 2 and 1 cycles respectively.
- turbo_req 0→3 asserted at cnt=5 → turbo_mode stays 0 until the wrap edge. turbo_ack pulses once in the cycle div_en[3] is high. Continuous cpu_en begins from that cycle.
- Mode 0 with CPUContention high across one tick → that cpu_en is missing and the next occurs 8 cycles later. In mode 2, the same contention has no effect.
- cpu_hold high for 3 cycles covering one mode-2 tick → exactly one cpu_en dropped. div_en outputs are unaffected.
- rst asserted mid-period with a turbo change pending → all outputs 0 immediately. After release, turbo_mode=0 and the cycle-1 pattern matches scenario 1.
